// File: rtl/hack_run_pkg.sv
// hack_run_pkg: shared encodings for the Hack run-control sequencer.
//   run_state_t : BOOT/HALT/RUN/STEP as seen on o_run_state
//   cmd_op_t    : host command opcodes carried on i_cmd_op
//   NOP_INSN_DEFAULT : C-instruction "comp 0, no dest, no jump"
package hack_run_pkg;

    typedef enum logic [1:0] {
        RS_BOOT = 2'd0,
        RS_HALT = 2'd1,
        RS_RUN  = 2'd2,
        RS_STEP = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_RUN       = 3'd1,
        OP_HALT      = 3'd2,
        OP_STEP      = 3'd3,
        OP_RESET_CPU = 3'd4,
        OP_SET_BRK   = 3'd5,
        OP_CLR_BRK   = 3'd6,
        OP_RSVD      = 3'd7
    } cmd_op_t;

    localparam logic [15:0] NOP_INSN_DEFAULT = 16'hEA80;

endpackage

// File: rtl/hack_run_ctrl.sv
// hack_run_ctrl: run-control sequencer for the Hack CPU (boot reset, run/halt/step, breakpoint).
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready : host command handshake; i_cmd_op opcode, i_cmd_data breakpoint address
//   i_pc_in, i_rom_instruction : CPU program counter and ROM word at that address
//   o_cpu_instruction       : ROM word when executing, NOP_INSN otherwise
//   o_cpu_reset, o_cpu_hlt  : CPU control
//   o_run_state, o_brk_hit  : status; o_cycle_count executed-instruction count
//   Macro HACK_RUN_CTRL_CYCLE_CNT_EN enables the cycle counter; otherwise o_cycle_count is 0.
module hack_run_ctrl
    import hack_run_pkg::*;
#(
    parameter int          RESET_CYCLES = 4,
    parameter logic [15:0] NOP_INSN     = NOP_INSN_DEFAULT,
    parameter int          CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [14:0]      i_cmd_data,
    input  logic [14:0]      i_pc_in,
    input  logic [15:0]      i_rom_instruction,
    output logic [15:0]      o_cpu_instruction,
    output logic             o_cpu_reset,
    output logic             o_cpu_hlt,
    output logic [1:0]       o_run_state,
    output logic             o_brk_hit,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int BW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    run_state_t  r_state, w_state_nxt;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic        r_brk_en, w_brk_en_nxt;
    logic [14:0] r_brk_addr, w_brk_addr_nxt;
    logic        r_brk_hit, w_brk_hit_nxt;
    logic        r_skip_brk, w_skip_nxt;
    logic        w_accept, w_brk_match, w_exec;
    cmd_op_t     w_op;

    assign w_op        = cmd_op_t'(i_cmd_op);
    assign o_cmd_ready = (r_state == RS_HALT) || (r_state == RS_RUN);
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    // skip_brk lets RUN resume from the very address that stopped it
    assign w_brk_match = r_brk_en && !r_skip_brk && (i_pc_in == r_brk_addr);
    assign w_exec      = ((r_state == RS_RUN) && !w_brk_match) || (r_state == RS_STEP);

    assign o_cpu_instruction = w_exec ? i_rom_instruction : NOP_INSN;
    assign o_cpu_hlt         = !w_exec;
    assign o_cpu_reset       = (r_state == RS_BOOT);
    assign o_run_state       = r_state;
    assign o_brk_hit         = r_brk_hit;

    always_comb begin
        w_state_nxt    = r_state;
        w_bcnt_nxt     = r_bcnt;
        w_brk_en_nxt   = r_brk_en;
        w_brk_addr_nxt = r_brk_addr;
        w_brk_hit_nxt  = r_brk_hit;
        w_skip_nxt     = r_skip_brk;
        case (r_state)
            RS_BOOT: begin
                if (r_bcnt == BW'(RESET_CYCLES - 1)) w_state_nxt = RS_HALT;
                else w_bcnt_nxt = r_bcnt + 1'b1;
            end
            RS_HALT: begin
                if (w_accept) begin
                    case (w_op)
                        OP_RUN: begin
                            w_state_nxt   = RS_RUN;
                            w_skip_nxt    = 1'b1;
                            w_brk_hit_nxt = 1'b0;
                        end
                        OP_STEP: begin
                            w_state_nxt   = RS_STEP;
                            w_brk_hit_nxt = 1'b0;
                        end
                        OP_RESET_CPU: begin
                            w_state_nxt   = RS_BOOT;
                            w_bcnt_nxt    = '0;
                            w_brk_hit_nxt = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            RS_RUN: begin
                w_skip_nxt = 1'b0;
                if (w_brk_match) begin
                    w_state_nxt   = RS_HALT;
                    w_brk_hit_nxt = 1'b1;
                end
                // RESET_CPU overrides a simultaneous breakpoint hit
                if (w_accept && w_op == OP_RESET_CPU) begin
                    w_state_nxt   = RS_BOOT;
                    w_bcnt_nxt    = '0;
                    w_brk_hit_nxt = 1'b0;
                end else if (w_accept && w_op == OP_HALT) begin
                    w_state_nxt = RS_HALT;
                end
            end
            default: w_state_nxt = RS_HALT;
        endcase
        if (w_accept && w_op == OP_SET_BRK) begin
            w_brk_addr_nxt = i_cmd_data;
            w_brk_en_nxt   = 1'b1;
        end
        if (w_accept && w_op == OP_CLR_BRK) w_brk_en_nxt = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= RS_BOOT;
            r_bcnt     <= '0;
            r_brk_en   <= 1'b0;
            r_brk_addr <= '0;
            r_brk_hit  <= 1'b0;
            r_skip_brk <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_brk_en   <= w_brk_en_nxt;
            r_brk_addr <= w_brk_addr_nxt;
            r_brk_hit  <= w_brk_hit_nxt;
            r_skip_brk <= w_skip_nxt;
        end
    end

`ifdef HACK_RUN_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cycle_count;
    logic             w_clr_cnt;

    assign w_clr_cnt     = w_accept && (w_op == OP_RESET_CPU);
    assign o_cycle_count = r_cycle_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_cycle_count <= '0;
        else if (w_clr_cnt) r_cycle_count <= '0;
        else if (w_exec) r_cycle_count <= r_cycle_count + 1'b1;
    end
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_hack_run_ctrl.sv
// tb_hack_run_ctrl: table-driven, scoreboarded bench for hack_run_ctrl.
module tb_hack_run_ctrl;
    import hack_run_pkg::*;

    localparam logic [15:0] N = 16'hEA80;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [14:0] cmd_data;
    logic [14:0] pc_in;
    logic [15:0] rom_instruction;
    logic [15:0] cpu_instruction;
    logic        cpu_reset;
    logic        cpu_hlt;
    logic [1:0]  run_state;
    logic        brk_hit;
    logic [31:0] cycle_count;

    hack_run_ctrl #(.RESET_CYCLES(4), .NOP_INSN(16'hEA80), .CNT_W(32)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op),
        .i_cmd_data(cmd_data),
        .i_pc_in(pc_in),
        .i_rom_instruction(rom_instruction),
        .o_cpu_instruction(cpu_instruction),
        .o_cpu_reset(cpu_reset),
        .o_cpu_hlt(cpu_hlt),
        .o_run_state(run_state),
        .o_brk_hit(brk_hit),
        .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [14:0] d;
        logic [14:0] pc;
        logic [15:0] rom;
        logic [1:0]  st;
        logic        rdy;
        logic [15:0] insn;
        logic        hlt;
        logic        rst;
        logic        hit;
    } vec_t;

    vec_t        tbl[$];
    vec_t        sb[$];
    int          total = 0;
    int          passed = 0;
    logic [31:0] exp_cnt = 0;

    function automatic vec_t r(input logic v, input logic [2:0] op, input logic [14:0] d,
                               input logic [14:0] pc, input logic [15:0] rom, input logic [1:0] st,
                               input logic rdy, input logic [15:0] insn, input logic hlt,
                               input logic rst, input logic hit);
        vec_t x;
        x.v = v; x.op = op; x.d = d; x.pc = pc; x.rom = rom; x.st = st;
        x.rdy = rdy; x.insn = insn; x.hlt = hlt; x.rst = rst; x.hit = hit;
        return x;
    endfunction

    function automatic logic [31:0] cnt_model();
`ifdef HACK_RUN_CTRL_CYCLE_CNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        else passed++;
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        cmd_valid = v.v; cmd_op = v.op; cmd_data = v.d; pc_in = v.pc; rom_instruction = v.rom;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk("run_state", 32'(run_state), 32'(e.st));
        chk("cmd_ready", 32'(cmd_ready), 32'(e.rdy));
        chk("cpu_instruction", 32'(cpu_instruction), 32'(e.insn));
        chk("cpu_hlt", 32'(cpu_hlt), 32'(e.hlt));
        chk("cpu_reset", 32'(cpu_reset), 32'(e.rst));
        chk("brk_hit", 32'(brk_hit), 32'(e.hit));
        chk("cycle_count", cycle_count, cnt_model());
        if (e.v && e.rdy && e.op == OP_RESET_CPU) exp_cnt = 0;
        else if (!e.hlt) exp_cnt++;
    endtask

    task automatic wait_halt();
        cmd_valid = 1'b0; cmd_op = OP_NOP;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (run_state == RS_HALT) break;
        end
        chk("boot_done", 32'(run_state), 32'(RS_HALT));
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0; pc_in = '0; rom_instruction = '0;
        #1 reset = 1'b1;
        #2;
        chk("rst_state", 32'(run_state), 32'(RS_BOOT));
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_hlt", 32'(cpu_hlt), 32'd1);
        chk("rst_insn", 32'(cpu_instruction), 32'(N));
        chk("rst_brk_hit", 32'(brk_hit), 32'd0);
        chk("rst_count", cycle_count, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 4; i++) tbl.push_back(r(1, OP_RUN, 0, 0, 16'h1234, RS_BOOT, 0, N, 1, 1, 0));
        tbl.push_back(r(0, OP_NOP, 0, 0, 16'h1234, RS_HALT, 1, N, 1, 0, 0));
        tbl.push_back(r(1, OP_RUN, 0, 15'h100, 16'h2000, RS_HALT, 1, N, 1, 0, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(r(0, OP_NOP, 0, 15'(15'h100 + i), 16'(16'h2000 + i), RS_RUN, 1, 16'(16'h2000 + i), 0, 0, 0));
        tbl.push_back(r(1, OP_HALT, 0, 15'h10A, 16'h200A, RS_RUN, 1, 16'h200A, 0, 0, 0));
        tbl.push_back(r(0, OP_NOP, 0, 15'h10B, 16'h200B, RS_HALT, 1, N, 1, 0, 0));
        tbl.push_back(r(1, OP_STEP, 0, 15'h5, 16'h0005, RS_HALT, 1, N, 1, 0, 0));
        tbl.push_back(r(1, OP_RUN, 0, 15'h5, 16'h0005, RS_STEP, 0, 16'h0005, 0, 0, 0));
        tbl.push_back(r(0, OP_NOP, 0, 15'h6, 16'h0005, RS_HALT, 1, N, 1, 0, 0));
        tbl.push_back(r(1, OP_SET_BRK, 15'h10, 0, 16'h3000, RS_HALT, 1, N, 1, 0, 0));
        tbl.push_back(r(1, OP_RUN, 0, 0, 16'h3000, RS_HALT, 1, N, 1, 0, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(r(0, OP_NOP, 0, 15'(i), 16'(16'h3000 + i), RS_RUN, 1, 16'(16'h3000 + i), 0, 0, 0));
        tbl.push_back(r(0, OP_NOP, 0, 15'h10, 16'h3010, RS_RUN, 1, N, 1, 0, 0));
        tbl.push_back(r(0, OP_NOP, 0, 15'h10, 16'h3010, RS_HALT, 1, N, 1, 0, 1));
        tbl.push_back(r(1, OP_RUN, 0, 15'h10, 16'h3010, RS_HALT, 1, N, 1, 0, 1));
        tbl.push_back(r(0, OP_NOP, 0, 15'h10, 16'h3010, RS_RUN, 1, 16'h3010, 0, 0, 0));
        tbl.push_back(r(0, OP_NOP, 0, 15'h11, 16'h3011, RS_RUN, 1, 16'h3011, 0, 0, 0));
        tbl.push_back(r(1, OP_HALT, 0, 15'h12, 16'h3012, RS_RUN, 1, 16'h3012, 0, 0, 0));
        tbl.push_back(r(0, OP_NOP, 0, 15'h10, 16'h3010, RS_HALT, 1, N, 1, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        apply(r(1, OP_RUN, 0, 15'h20, 16'h4020, RS_HALT, 1, N, 1, 0, 0));
        apply(r(0, OP_NOP, 0, 15'h20, 16'h4020, RS_RUN, 1, 16'h4020, 0, 0, 0));
        apply(r(1, OP_HALT, 0, 15'h10, 16'h4010, RS_RUN, 1, N, 1, 0, 0));
        apply(r(0, OP_NOP, 0, 15'h10, 16'h4010, RS_HALT, 1, N, 1, 0, 1));
        apply(r(1, OP_RUN, 0, 15'h21, 16'h4021, RS_HALT, 1, N, 1, 0, 1));
        apply(r(0, OP_NOP, 0, 15'h21, 16'h4021, RS_RUN, 1, 16'h4021, 0, 0, 0));
        apply(r(1, OP_RESET_CPU, 0, 15'h10, 16'h4010, RS_RUN, 1, N, 1, 0, 0));
        apply(r(0, OP_NOP, 0, 15'h10, 16'h4010, RS_BOOT, 0, N, 1, 1, 0));
        wait_halt();

        apply(r(1, OP_RUN, 0, 15'h30, 16'h5030, RS_HALT, 1, N, 1, 0, 0));
        apply(r(0, OP_NOP, 0, 15'h31, 16'h5031, RS_RUN, 1, 16'h5031, 0, 0, 0));
        @(negedge clk);
        cmd_valid = 1'b0; pc_in = 15'h32; rom_instruction = 16'h5032;
        #2 reset = 1'b1;
        #1;
        exp_cnt = 0;
        chk("async_state", 32'(run_state), 32'(RS_BOOT));
        chk("async_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("async_cpu_hlt", 32'(cpu_hlt), 32'd1);
        chk("async_insn", 32'(cpu_instruction), 32'(N));
        chk("async_count", cycle_count, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        wait_halt();

        apply(r(1, OP_RUN, 0, 15'h40, 16'h6040, RS_HALT, 1, N, 1, 0, 0));
        apply(r(0, OP_NOP, 0, 15'h41, 16'h6041, RS_RUN, 1, 16'h6041, 0, 0, 0));
        apply(r(1, OP_HALT, 0, 15'h10, 16'h6010, RS_RUN, 1, 16'h6010, 0, 0, 0));
        apply(r(0, OP_NOP, 0, 15'h10, 16'h6010, RS_HALT, 1, N, 1, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hack_run_ctrl.md
Name: hack_run_ctrl

Overview:
- Run-control sequencer for the Hack CPU core.
- Holds the CPU in reset after power-up, then accepts RUN / HALT / STEP / breakpoint commands through a valid/ready port.
- Drives the CPU `reset` and `hlt` inputs.
- Gates the ROM instruction to a harmless NOP whenever the core must not execute, so no register or memory is written while halted.
- Sits between instruction ROM, CPU and the debug/host interface.

Parameters:
- RESET_CYCLES, 4, number of clk cycles `cpu_reset` is held in BOOT (minimum 1).
- NOP_INSN, 16'hEA80, instruction substituted when not executing (C-instr: comp 0, no dest, no jump).
- CNT_W, 32, width of the executed-cycle counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  controller can accept a command this cycle.
- cmd_op  input  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 RESET_CPU, 5 SET_BRK, 6 CLR_BRK, 7 reserved (treated as NOP).
- cmd_data  input  15  breakpoint address for SET_BRK; ignored otherwise.
- pc_in  input  15  CPU program counter; stable before each rising clk.
- rom_instruction  input  16  instruction fetched from ROM at pc_in.
- cpu_instruction  output  16  instruction presented to CPU.
- cpu_reset  output  1  to CPU reset.
- cpu_hlt  output  1  to CPU hlt.
- run_state  output  2  0 BOOT, 1 HALT, 2 RUN, 3 STEP.
- brk_hit  output  1  sticky; set when a breakpoint stopped execution.
- cycle_count  output  CNT_W  executed-instruction count.

Behaviour:
- Reset (async):
  - run_state=BOOT, boot counter=0, brk_en=0, brk_addr=0, brk_hit=0, skip_brk=0, cycle_count=0.
  - cpu_reset=1, cpu_hlt=1, cpu_instruction=NOP_INSN.
- Execute condition:
  - exec = (RUN & ~brk_match) | STEP.
  - brk_match = brk_en & ~skip_brk & (pc_in==brk_addr).
  - cpu_instruction = exec ? rom_instruction : NOP_INSN (combinational).
  - cpu_hlt = ~exec.
  - cpu_reset = (run_state==BOOT).
- State machine:
  - BOOT: count to RESET_CYCLES-1, then go to HALT. cmd_ready=0.
  - HALT: cmd_ready=1.
    - RUN → RUN, skip_brk=1.
    - STEP → STEP.
    - RESET_CPU → BOOT, counter=0.
    - SET_BRK: brk_addr=cmd_data, brk_en=1.
    - CLR_BRK: brk_en=0.
    - HALT/NOP/7: no effect.
    - Accepting RUN or STEP clears brk_hit.
  - RUN: cmd_ready=1.
    - skip_brk clears after the first RUN cycle.
    - brk_match → HALT, brk_hit=1; the matching instruction is not executed.
    - Otherwise, accepted HALT → HALT; that cycle still executes.
    - RESET_CPU → BOOT.
    - SET_BRK / CLR_BRK update breakpoint registers and stay in RUN; the new value takes effect next cycle.
    - RUN / STEP: no effect.
  - STEP: exactly one instruction executes, then → HALT. cmd_ready=0. Breakpoint is ignored.
- Simultaneous events:
  - brk_match and accepted HALT in the same cycle: brk_hit=1, go to HALT, instruction not executed.
  - brk_match and RESET_CPU in the same cycle: RESET_CPU wins, brk_hit=0.
- cycle_count:
  - Increments on every exec cycle and wraps at 2^CNT_W.
  - Cleared by reset and by RESET_CPU.
- Handshake: a command is consumed when cmd_valid & cmd_ready at a rising edge; one command per cycle.
- reset asserted mid-RUN or mid-STEP aborts immediately to BOOT; no instruction executes while reset is high.

Optional Feature:
- HACK_RUN_CTRL_CYCLE_CNT_EN:
  - Defined: the cycle_count register and logic are present as described.
  - Undefined: cycle_count is tied to 0 and no counter flops are synthesized.

Decomposition:
- Package hack_run_pkg holds:
  - run_state encodings (BOOT/HALT/RUN/STEP).
  - cmd_op encodings.
  - Default NOP_INSN constant 16'hEA80.
- No sub-module is required; the breakpoint comparator and counter stay inline.

Test Plan:
- Boot: reset pulse, RESET_CYCLES=4 → cpu_reset=1 for exactly 4 cycles after release, then run_state=HALT, cpu_hlt=1, cpu_instruction=16'hEA80.
- Run/halt: RUN, wait 10 cycles, HALT → cycle_count=11 (HALT cycle executes), cpu_instruction reverts to NOP the cycle after HALT is accepted.
- Step: from HALT with rom_instruction=16'h0005, STEP → cpu_instruction=16'h0005 and cpu_hlt=0 for exactly one cycle, then HALT, cycle_count+1, cmd_ready low during STEP.
- Breakpoint:
  - SET_BRK 15'h0010, RUN, drive pc_in counting from 0 → halt with pc_in=0x10, brk_hit=1, instruction at 0x10 not executed (NOP presented).
  - RUN again → 0x10 executes, brk_hit clears.
- Simultaneous: in RUN, pc_in=brk_addr and HALT command in the same cycle → HALT, brk_hit=1. Repeat with RESET_CPU → BOOT, brk_hit=0, cycle_count=0.
- Async reset mid-RUN: assert reset between clock edges → cpu_reset=1, cpu_hlt=1 immediately, brk_en=0 afterwards.
